// File: rtl/text_buffer_if.sv
// Raster-lookup and character-write bundle between the text source, the raster
// timing generator and text_buffer; the buffer takes the slave side.
interface text_buffer_if;
  logic [9:0] HorizontalCounter;
  logic [9:0] VerticalCounter;
  logic       wr_valid;
  logic [6:0] wr_char;
  logic       wr_ready;
  logic       busy;
  logic [6:0] address;
  logic [3:0] glyph_line;
  logic [2:0] glyph_col;
  logic       active;

  modport master (
    output HorizontalCounter, VerticalCounter, wr_valid, wr_char,
    input  wr_ready, busy, address, glyph_line, glyph_col, active
  );

  modport slave (
    input  HorizontalCounter, VerticalCounter, wr_valid, wr_char,
    output wr_ready, busy, address, glyph_line, glyph_col, active
  );
endinterface

// File: rtl/text_buffer.sv
// 80x40 character-cell memory with cursor-driven write port and a 2-cycle raster lookup
// feeding font_rom. Define TEXT_BUFFER_CURSOR_EN to blink a block glyph at the cursor.
module text_buffer #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 40,
  parameter logic [6:0] BLANK = 7'h20
) (
  input  logic         clock25,
  input  logic         reset,
  text_buffer_if.slave bus
);

  localparam int          CELLS    = COLS * ROWS;
  localparam logic [11:0] LAST_IDX = 12'(CELLS - 1);
  localparam logic [0:0]  ST_CLEAR = 1'b0;
  localparam logic [0:0]  ST_IDLE  = 1'b1;

  function automatic logic [11:0] cell_idx(input logic [5:0] row, input logic [6:0] col);
    return 12'(row) * 12'(COLS) + 12'(col);
  endfunction

  logic [6:0] mem [0:CELLS-1];

  logic [0:0]  state;
  logic [11:0] clr_idx;
  logic [6:0]  cur_col;
  logic [5:0]  cur_row;
  logic        busy_w;

  logic [9:0]  h, v;
  logic        in_area;
  logic [5:0]  scan_row;
  logic [6:0]  scan_col;
  logic [3:0]  scan_line;

  logic [11:0] idx_p0;
  logic        vld_p0, vld_p1;
  logic [3:0]  line_p0, line_p1;
  logic [2:0]  col_p0, col_p1;
  logic [6:0]  ram_q;

  logic        handshake, printable;
  logic        wr_en_c;
  logic [11:0] wr_addr_c;
  logic [6:0]  wr_data_c;
  logic        we_q;
  logic [11:0] waddr_q;
  logic [6:0]  wdata_q;
  logic [5:0]  next_row;

  assign h         = bus.HorizontalCounter;
  assign v         = bus.VerticalCounter;
  assign in_area   = (v < 10'(ROWS * 12)) && (h < 10'(COLS * 8));
  assign scan_row  = 6'(v / 10'd12);
  assign scan_col  = h[9:3];
  assign scan_line = 4'(v % 10'd12);

  assign busy_w       = (state == ST_CLEAR);
  assign bus.busy     = busy_w;
  assign bus.wr_ready = (state == ST_IDLE);
  assign handshake    = bus.wr_valid && (state == ST_IDLE);
  assign printable    = (bus.wr_char >= 7'h20) && (bus.wr_char <= 7'h7E);
  assign next_row     = (cur_row == 6'(ROWS - 1)) ? 6'd0 : cur_row + 6'd1;

  // Stage p0: cell index and in-cell position
  always_ff @(posedge clock25 or posedge reset) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      line_p0 <= 4'd0;
      col_p0  <= 3'd0;
    end else begin
      vld_p0  <= in_area;
      line_p0 <= scan_line;
      col_p0  <= h[2:0];
    end
  end

  always_ff @(posedge clock25) begin
    idx_p0 <= in_area ? cell_idx(scan_row, scan_col) : 12'd0;
  end

  // Stage p1: synchronous RAM read (old data on same-cell write) and pending write
  always_ff @(posedge clock25) begin
    if (we_q) mem[waddr_q] <= wdata_q;
    ram_q <= mem[idx_p0];
  end

  always_ff @(posedge clock25 or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      line_p1 <= 4'd0;
      col_p1  <= 3'd0;
    end else begin
      vld_p1  <= vld_p0;
      line_p1 <= line_p0;
      col_p1  <= col_p0;
    end
  end

  assign bus.active     = vld_p1;
  assign bus.glyph_line = line_p1;
  assign bus.glyph_col  = col_p1;

`ifdef TEXT_BUFFER_CURSOR_EN
  logic [5:0] frame_cnt;
  logic       hit_c, hit_p0, hit_p1;

  assign hit_c = in_area && (scan_row == cur_row) && (scan_col == cur_col);

  always_ff @(posedge clock25 or posedge reset) begin
    if (reset) begin
      frame_cnt <= 6'd0;
      hit_p0    <= 1'b0;
      hit_p1    <= 1'b0;
    end else begin
      if (h == 10'd0 && v == 10'd480) frame_cnt <= frame_cnt + 6'd1;
      hit_p0 <= hit_c;
      hit_p1 <= hit_p0;
    end
  end

  assign bus.address = busy_w ? BLANK : ((frame_cnt[5] && hit_p1) ? 7'h7F : ram_q);
`else
  assign bus.address = busy_w ? BLANK : ram_q;
`endif

  // Write request decode: the RAM write itself is registered and lands one cycle later
  always_comb begin
    wr_en_c   = 1'b0;
    wr_addr_c = cell_idx(cur_row, cur_col);
    wr_data_c = BLANK;
    if (state == ST_CLEAR) begin
      wr_en_c   = 1'b1;
      wr_addr_c = clr_idx;
    end else if (handshake) begin
      if (bus.wr_char == 7'h08) begin
        if (cur_col != 7'd0) begin
          wr_en_c   = 1'b1;
          wr_addr_c = cell_idx(cur_row, cur_col - 7'd1);
        end
      end else if (printable) begin
        wr_en_c   = 1'b1;
        wr_data_c = bus.wr_char;
      end
    end
  end

  always_ff @(posedge clock25) begin
    waddr_q <= wr_addr_c;
    wdata_q <= wr_data_c;
  end

  always_ff @(posedge clock25 or posedge reset) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_idx <= 12'd0;
      cur_col <= 7'd0;
      cur_row <= 6'd0;
      we_q    <= 1'b0;
    end else begin
      we_q <= wr_en_c;
      case (state)
        ST_CLEAR: begin
          if (clr_idx == LAST_IDX) begin
            state   <= ST_IDLE;
            clr_idx <= 12'd0;
            cur_col <= 7'd0;
            cur_row <= 6'd0;
          end else begin
            clr_idx <= clr_idx + 12'd1;
          end
        end
        default: begin
          if (handshake) begin
            case (bus.wr_char)
              7'h0C: begin
                state   <= ST_CLEAR;
                clr_idx <= 12'd0;
              end
              7'h0D: cur_col <= 7'd0;
              7'h0A: begin
                cur_col <= 7'd0;
                cur_row <= next_row;
              end
              7'h08: if (cur_col != 7'd0) cur_col <= cur_col - 7'd1;
              default: begin
                if (printable) begin
                  if (cur_col == 7'(COLS - 1)) begin
                    cur_col <= 7'd0;
                    cur_row <= next_row;
                  end else begin
                    cur_col <= cur_col + 7'd1;
                  end
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_buffer.sv
// Bench for text_buffer: directed and random character streams scored against a
// screen/cursor model, with raster scans checked through the 2-cycle lookup.
module tb_text_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  text_buffer_if bus();

  text_buffer dut (
    .clock25 (clk),
    .reset   (rst),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] m_mem [3200];
  int         m_col, m_row, m_frames;
  bit         m_busy;
  int         ph[$], pv[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_clear();
    for (int i = 0; i < 3200; i++) m_mem[i] = 7'h20;
    m_col = 0;
    m_row = 0;
  endfunction

  function automatic void m_apply(input logic [6:0] c);
    if (c == 7'h0C) m_clear();
    else if (c == 7'h0D) m_col = 0;
    else if (c == 7'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % 40;
    end else if (c == 7'h08) begin
      if (m_col > 0) begin
        m_col--;
        m_mem[m_row * 80 + m_col] = 7'h20;
      end
    end else if (c >= 7'h20 && c <= 7'h7E) begin
      m_mem[m_row * 80 + m_col] = c;
      m_col++;
      if (m_col == 80) begin
        m_col = 0;
        m_row = (m_row + 1) % 40;
      end
    end
  endfunction

  function automatic logic [6:0] exp_addr(input int h, input int v);
    if (m_busy) return 7'h20;
    if (!(h < 640 && v < 480)) return m_mem[0];
`ifdef TEXT_BUFFER_CURSOR_EN
    if (((m_frames / 32) % 2) == 1 && (v / 12) == m_row && (h / 8) == m_col) return 7'h7F;
`endif
    return m_mem[(v / 12) * 80 + (h / 8)];
  endfunction

  task automatic idle_raster();
    bus.HorizontalCounter = 10'd700;
    bus.VerticalCounter   = 10'd0;
  endtask

  task automatic put(input logic [6:0] c);
    @(negedge clk);
    check("wr_ready", bus.wr_ready, 1);
    bus.wr_valid = 1'b1;
    bus.wr_char  = c;
    @(posedge clk);
    m_apply(c);
  endtask

  task automatic idle_wr();
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic add_row(input int r);
    for (int c = 0; c < 80; c++) begin
      ph.push_back(c * 8 + int'($urandom_range(0, 7)));
      pv.push_back(r * 12 + int'($urandom_range(0, 11)));
    end
  endtask

  task automatic add_inactive(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        ph.push_back(int'($urandom_range(640, 1023)));
        pv.push_back(int'($urandom_range(0, 479)));
      end else begin
        ph.push_back(int'($urandom_range(0, 1023)));
        pv.push_back(int'($urandom_range(481, 1023)));
      end
    end
  endtask

  task automatic run_stream();
    int n, h, v;
    n = ph.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        h = ph[i-2];
        v = pv[i-2];
        check("address",    bus.address,    exp_addr(h, v));
        check("glyph_line", bus.glyph_line, v % 12);
        check("glyph_col",  bus.glyph_col,  h % 8);
        check("active",     bus.active,     (h < 640 && v < 480) ? 1 : 0);
      end
      if (i < n) begin
        bus.HorizontalCounter = 10'(ph[i]);
        bus.VerticalCounter   = 10'(pv[i]);
      end else begin
        idle_raster();
      end
    end
    ph.delete();
    pv.delete();
  endtask

  task automatic wait_clear(input string tag);
    int cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (bus.busy === 1'b1 && cyc < 5000);
    check(tag, cyc, 3200);
    m_busy = 1'b0;
    check("wr_ready_after_clear", bus.wr_ready, 1);
  endtask

  task automatic check_reset();
    check("rst_busy",       bus.busy,       1);
    check("rst_wr_ready",   bus.wr_ready,   0);
    check("rst_address",    bus.address,    7'h20);
    check("rst_glyph_line", bus.glyph_line, 0);
    check("rst_glyph_col",  bus.glyph_col,  0);
    check("rst_active",     bus.active,     0);
  endtask

  task automatic frame_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.HorizontalCounter = 10'd0;
      bus.VerticalCounter   = 10'd480;
      @(posedge clk);
      m_frames++;
    end
    @(negedge clk);
    idle_raster();
  endtask

  function automatic logic [6:0] rand_code();
    int r;
    logic [6:0] others [5];
    others = '{7'h00, 7'h1B, 7'h7F, 7'h0B, 7'h0E};
    r = int'($urandom_range(0, 19));
    if (r == 14) return 7'h0D;
    if (r == 15) return 7'h0A;
    if (r == 16 || r == 17) return 7'h08;
    if (r == 18) return others[$urandom_range(0, 4)];
    return 7'($urandom_range(32, 126));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_char  = 7'h00;
    idle_raster();
    m_frames = 0;
    m_busy   = 1'b1;
    m_clear();

    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;
    wait_clear("clear_len_after_reset");

    add_row(0); add_row(17); add_row(39); add_inactive(20);
    run_stream();

    put(7'h41); put(7'h42); idle_wr();
    ph = '{0, 8}; pv = '{0, 0};
    run_stream();
    add_row(0);
    run_stream();

    for (int i = 0; i < 78; i++) put(7'($urandom_range(32, 126)));
    put(7'h5A); idle_wr();
    add_row(0); add_row(1);
    run_stream();

    for (int i = 0; i < 38; i++) put(7'h0A);
    put(7'h78); put(7'h0A); put(7'h79); idle_wr();
    add_row(39); add_row(0); add_row(1);
    run_stream();

    put(7'h0D); put(7'h51); put(7'h08); put(7'h08); idle_wr();
    ph = '{0, 8}; pv = '{0, 0};
    run_stream();
    put(7'h52); idle_wr();
    add_row(0);
    run_stream();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle_wr();
      else put(rand_code());
    end
    idle_wr();
    for (int r = 0; r < 40; r++) add_row(r);
    add_inactive(30);
    run_stream();

`ifdef TEXT_BUFFER_CURSOR_EN
    put(7'h0D); put(7'h4B); put(7'h4C); put(7'h4D); put(7'h08); idle_wr();
    frame_pulses(32);
    add_row(m_row);
    run_stream();
    frame_pulses(32);
    add_row(m_row);
    run_stream();
`endif

    put(7'h54); put(7'h0C);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    m_busy = 1'b1;
    check("ff_busy_rise",    bus.busy,     1);
    check("ff_wr_ready_low", bus.wr_ready, 0);
    wait_clear("clear_len_form_feed");
    add_row(0); add_row(m_row + 20);
    run_stream();

    for (int i = 0; i < 90; i++) put(7'($urandom_range(32, 126)));
    put(7'h0C);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    m_busy = 1'b1;
    add_row(0); add_row(1);
    run_stream();
    repeat (1000 - 162) @(negedge clk);
    check("busy_mid_clear", bus.busy, 1);
    rst = 1'b1;
    #1;
    check_reset();
    m_frames = 0;
    repeat (2) @(negedge clk);
    check("busy_in_reset", bus.busy, 1);
    rst = 1'b0;
    wait_clear("clear_len_restart");
    add_row(0); add_row(1);
    run_stream();
    put(7'h41); idle_wr();
    ph = '{3, 11}; pv = '{5, 0};
    run_stream();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
